// File: rtl/lavadora_pkg.sv
// Shared encodings and stage-duration defaults for the washer sequencer.
package lavadora_pkg;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_LLENADO      = 3'd1,
    S_LAVADO       = 3'd2,
    S_DRENADO      = 3'd3,
    S_CENTRIFUGADO = 3'd4,
    S_SECADO       = 3'd5,
    S_PAUSA        = 3'd6,
    S_FIN          = 3'd7
  } estado_t;

  typedef enum logic [1:0] {
    P_NONE   = 2'd0,
    P_NORMAL = 2'd1,
    P_PESADO = 2'd2,
    P_SECA   = 2'd3
  } programa_t;

  localparam int DEF_W              = 8;
  localparam int DEF_T_LLENADO      = 4;
  localparam int DEF_T_LAVADO       = 8;
  localparam int DEF_T_DRENADO      = 3;
  localparam int DEF_T_CENTRIFUGADO = 5;
  localparam int DEF_T_SECADO       = 10;

  // Counter preload for a stage of t cycles; a zero-length stage still runs one cycle.
  function automatic int ciclos_carga(input int t);
    return (t <= 0) ? 0 : t - 1;
  endfunction

endpackage

// File: rtl/lavadora_if.sv
// Request/door inputs and actuator/status outputs of the washer sequencer.
interface lavadora_if;
  // Requests are level signals held by the payment side and sampled only in IDLE
  // with the door closed; FIN stays high until the door opens, which acknowledges
  // completion and returns the sequencer to IDLE.
  logic       LAVADO;
  logic       LAVADO_PESADO;
  logic       SECADO;
  logic       INSUFICIENTE;
  logic       PUERTA_CERRADA;
  logic       LLENAR;
  logic       MOTOR_LAVADO;
  logic       DRENAR;
  logic       CENTRIFUGAR;
  logic       SECAR;
  logic       PUERTA_BLOQUEADA;
  logic       FIN;
  logic [2:0] ETAPA;

  modport master (
    output LAVADO, LAVADO_PESADO, SECADO, INSUFICIENTE, PUERTA_CERRADA,
    input  LLENAR, MOTOR_LAVADO, DRENAR, CENTRIFUGAR, SECAR,
           PUERTA_BLOQUEADA, FIN, ETAPA
  );

  modport slave (
    input  LAVADO, LAVADO_PESADO, SECADO, INSUFICIENTE, PUERTA_CERRADA,
    output LLENAR, MOTOR_LAVADO, DRENAR, CENTRIFUGAR, SECAR,
           PUERTA_BLOQUEADA, FIN, ETAPA
  );
endinterface

// File: rtl/temporizador_etapa.sv
// Loadable down-counter timing one stage; holds at zero and freezes when not enabled.
module temporizador_etapa #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         carga,
  input  logic         habilita,
  input  logic [W-1:0] valor,
  output logic         cero
);

  logic [W-1:0] cuenta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cuenta <= '0;
    end else if (carga) begin
      cuenta <= valor;
    end else if (habilita && (cuenta != '0)) begin
      cuenta <= cuenta - 1'b1;
    end
  end

  assign cero = (cuenta == '0);

endmodule

// File: rtl/secuenciador_lavadora.sv
// Wash/dry program sequencer: timed stages, door interlock with pause/resume,
// and end-of-cycle hold until the door is opened.
module secuenciador_lavadora
  import lavadora_pkg::*;
#(
  parameter int W              = DEF_W,
  parameter int T_LLENADO      = DEF_T_LLENADO,
  parameter int T_LAVADO       = DEF_T_LAVADO,
  parameter int T_DRENADO      = DEF_T_DRENADO,
  parameter int T_CENTRIFUGADO = DEF_T_CENTRIFUGADO,
  parameter int T_SECADO       = DEF_T_SECADO
) (
  input logic       clk,
  input logic       reset,
  lavadora_if.slave bus
);

  localparam logic [W-1:0] C_LLENADO      = W'(ciclos_carga(T_LLENADO));
  localparam logic [W-1:0] C_LAVADO       = W'(ciclos_carga(T_LAVADO));
  localparam logic [W-1:0] C_DRENADO      = W'(ciclos_carga(T_DRENADO));
  localparam logic [W-1:0] C_CENTRIFUGADO = W'(ciclos_carga(T_CENTRIFUGADO));
  localparam logic [W-1:0] C_SECADO       = W'(ciclos_carga(T_SECADO));

  estado_t      estado, estado_d;
  estado_t      retorno, retorno_d;
  programa_t    prog, prog_d;
  logic         pasada, pasada_d;
  logic         carga, habilita, cero;
  logic [W-1:0] valor_carga;
  logic         llenar_q, motor_q, drenar_q, centrifugar_q, secar_q, bloqueo_q, fin_q;

  function automatic logic [W-1:0] carga_de(input estado_t e);
    case (e)
      S_LLENADO:      return C_LLENADO;
      S_LAVADO:       return C_LAVADO;
      S_DRENADO:      return C_DRENADO;
      S_CENTRIFUGADO: return C_CENTRIFUGADO;
      S_SECADO:       return C_SECADO;
      default:        return '0;
    endcase
  endfunction

  temporizador_etapa #(.W(W)) u_temporizador (
    .clk      (clk),
    .reset    (reset),
    .carga    (carga),
    .habilita (habilita),
    .valor    (valor_carga),
    .cero     (cero)
  );

  assign valor_carga = carga_de(estado_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado  <= S_IDLE;
      retorno <= S_IDLE;
      prog    <= P_NONE;
      pasada  <= 1'b0;
    end else begin
      estado  <= estado_d;
      retorno <= retorno_d;
      prog    <= prog_d;
      pasada  <= pasada_d;
    end
  end

  always_comb begin
    estado_d  = estado;
    retorno_d = retorno;
    prog_d    = prog;
    pasada_d  = pasada;
    carga     = 1'b0;
    habilita  = 1'b0;
    case (estado)
      S_IDLE: begin
        pasada_d = 1'b0;
        // An insufficient-payment flag vetoes any start.
        if (bus.PUERTA_CERRADA && !bus.INSUFICIENTE) begin
          if (bus.LAVADO_PESADO) begin
            prog_d   = P_PESADO;
            estado_d = S_LLENADO;
            carga    = 1'b1;
          end else if (bus.LAVADO) begin
            prog_d   = P_NORMAL;
            estado_d = S_LLENADO;
            carga    = 1'b1;
          end else if (bus.SECADO) begin
            prog_d   = P_SECA;
            estado_d = S_SECADO;
            carga    = 1'b1;
          end
        end
      end
      S_LLENADO, S_LAVADO, S_DRENADO, S_CENTRIFUGADO, S_SECADO: begin
        // Door open beats stage expiry; the counter is left untouched.
        if (!bus.PUERTA_CERRADA) begin
          estado_d  = S_PAUSA;
          retorno_d = estado;
        end else if (cero) begin
          carga = 1'b1;
          case (estado)
            S_LLENADO: estado_d = S_LAVADO;
            S_LAVADO:  estado_d = S_DRENADO;
            S_DRENADO: begin
              if (prog == P_PESADO && !pasada) begin
                pasada_d = 1'b1;
                estado_d = S_LLENADO;
              end else begin
                estado_d = S_CENTRIFUGADO;
              end
            end
            default:   estado_d = S_FIN;
          endcase
        end else begin
          habilita = 1'b1;
        end
      end
      S_PAUSA: begin
        if (bus.PUERTA_CERRADA) estado_d = retorno;
      end
      S_FIN: begin
        if (!bus.PUERTA_CERRADA) begin
          estado_d = S_IDLE;
          prog_d   = P_NONE;
        end
      end
      default: estado_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with ETAPA.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      llenar_q      <= 1'b0;
      motor_q       <= 1'b0;
      drenar_q      <= 1'b0;
      centrifugar_q <= 1'b0;
      secar_q       <= 1'b0;
      bloqueo_q     <= 1'b0;
      fin_q         <= 1'b0;
    end else begin
      llenar_q      <= (estado_d == S_LLENADO);
      motor_q       <= (estado_d == S_LAVADO);
      drenar_q      <= (estado_d == S_DRENADO);
      centrifugar_q <= (estado_d == S_CENTRIFUGADO);
      secar_q       <= (estado_d == S_SECADO);
      bloqueo_q     <= (estado_d != S_IDLE) && (estado_d != S_FIN);
      fin_q         <= (estado_d == S_FIN);
    end
  end

  assign bus.LLENAR           = llenar_q;
  assign bus.MOTOR_LAVADO     = motor_q;
  assign bus.DRENAR           = drenar_q;
  assign bus.CENTRIFUGAR      = centrifugar_q;
  assign bus.SECAR            = secar_q;
  assign bus.PUERTA_BLOQUEADA = bloqueo_q;
  assign bus.FIN              = fin_q;
  assign bus.ETAPA            = estado;

endmodule

// File: tb/tb_secuenciador_lavadora.sv
// Directed bench for the washer sequencer: program timing, door pause, start
// gating and asynchronous reset, checked cycle by cycle against hand-built tables.
module tb_secuenciador_lavadora;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [9:0] exp_q[$];

  lavadora_if bus ();

  secuenciador_lavadora dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ETAPA, LLENAR, MOTOR_LAVADO, DRENAR, CENTRIFUGAR, SECAR, PUERTA_BLOQUEADA, FIN}
  function automatic logic [9:0] obs();
    return {bus.ETAPA, bus.LLENAR, bus.MOTOR_LAVADO, bus.DRENAR, bus.CENTRIFUGAR,
            bus.SECAR, bus.PUERTA_BLOQUEADA, bus.FIN};
  endfunction

  function automatic logic [9:0] esperado(input int e);
    logic [9:0] v;
    v[9:7] = 3'(e);
    v[6]   = (e == 1);
    v[5]   = (e == 2);
    v[4]   = (e == 3);
    v[3]   = (e == 4);
    v[2]   = (e == 5);
    v[1]   = (e != 0) && (e != 7);
    v[0]   = (e == 7);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic encolar(input int e, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(esperado(e));
  endtask

  task automatic test_reset();
    logic [9:0] got;
    reset = 1'b1;
    bus.LAVADO = 1'b1;
    bus.LAVADO_PESADO = 1'b0;
    bus.SECADO = 1'b0;
    bus.INSUFICIENTE = 1'b0;
    bus.PUERTA_CERRADA = 1'b1;
    repeat (3) tick();
    got = obs();
    n_checks++;
    if (got !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", got, 10'b0);
    end
  endtask

  task automatic test_normal();
    logic [9:0] got, exp;
    reset = 1'b0;
    encolar(1, 4); encolar(2, 8); encolar(3, 3); encolar(4, 5); encolar(7, 1);
    for (int c = 1; c <= 21; c++) begin
      tick();
      got = obs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL normal cycle %0d: got %b expected %b", c, got, exp);
      end
    end
    repeat (3) tick();
    got = obs();
    n_checks++;
    if (got !== esperado(7)) begin
      n_fail++;
      $display("FAIL normal_fin_hold: got %b expected %b", got, esperado(7));
    end
    bus.PUERTA_CERRADA = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      got = obs();
      n_checks++;
      if (got !== esperado(0)) begin
        n_fail++;
        $display("FAIL normal_door_release %0d: got %b expected %b", c, got, esperado(0));
      end
    end
    bus.LAVADO = 1'b0;
    bus.PUERTA_CERRADA = 1'b1;
    tick();
  endtask

  task automatic test_pesado();
    logic [9:0] got, exp;
    bus.LAVADO_PESADO = 1'b1;
    bus.LAVADO = 1'b1;
    encolar(1, 4); encolar(2, 8); encolar(3, 3);
    encolar(1, 4); encolar(2, 8); encolar(3, 3);
    encolar(4, 5); encolar(7, 1);
    for (int c = 1; c <= 36; c++) begin
      tick();
      got = obs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL pesado cycle %0d: got %b expected %b", c, got, exp);
      end
      if (c == 1) begin
        bus.LAVADO_PESADO = 1'b0;
        bus.LAVADO = 1'b0;
      end
      if (c == 10) bus.SECADO = 1'b1;
      if (c == 20) bus.SECADO = 1'b0;
    end
    bus.PUERTA_CERRADA = 1'b0;
    tick();
    got = obs();
    n_checks++;
    if (got !== esperado(0)) begin
      n_fail++;
      $display("FAIL pesado_release: got %b expected %b", got, esperado(0));
    end
    bus.PUERTA_CERRADA = 1'b1;
    tick();
  endtask

  task automatic test_sin_arranque();
    logic [9:0] got;
    bus.INSUFICIENTE = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      got = obs();
      n_checks++;
      if (got !== esperado(0)) begin
        n_fail++;
        $display("FAIL insuficiente cycle %0d: got %b expected %b", c, got, esperado(0));
      end
    end
    bus.INSUFICIENTE = 1'b0;
    bus.PUERTA_CERRADA = 1'b0;
    bus.LAVADO = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      got = obs();
      n_checks++;
      if (got !== esperado(0)) begin
        n_fail++;
        $display("FAIL door_open_start cycle %0d: got %b expected %b", c, got, esperado(0));
      end
    end
    bus.LAVADO = 1'b0;
    bus.PUERTA_CERRADA = 1'b1;
    tick();
  endtask

  task automatic test_pausa();
    logic [9:0] got, exp;
    bus.LAVADO = 1'b1;
    encolar(1, 4); encolar(2, 3); encolar(6, 6); encolar(2, 6);
    encolar(3, 3); encolar(4, 5); encolar(7, 1);
    for (int c = 1; c <= 28; c++) begin
      tick();
      got = obs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL pausa cycle %0d: got %b expected %b", c, got, exp);
      end
      if (c == 1) bus.LAVADO = 1'b0;
      if (c == 7) bus.PUERTA_CERRADA = 1'b0;
      if (c == 13) bus.PUERTA_CERRADA = 1'b1;
    end
    bus.PUERTA_CERRADA = 1'b0;
    tick();
    bus.PUERTA_CERRADA = 1'b1;
    tick();
  endtask

  task automatic test_secado();
    logic [9:0] got, exp;
    bus.SECADO = 1'b1;
    encolar(5, 10); encolar(7, 1);
    for (int c = 1; c <= 11; c++) begin
      tick();
      got = obs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL secado cycle %0d: got %b expected %b", c, got, exp);
      end
      if (c == 1) bus.SECADO = 1'b0;
    end
    bus.PUERTA_CERRADA = 1'b0;
    tick();
    bus.PUERTA_CERRADA = 1'b1;
    tick();
  endtask

  task automatic test_pausa_expira();
    logic [9:0] got, exp;
    bus.SECADO = 1'b1;
    encolar(5, 10); encolar(6, 2); encolar(5, 1); encolar(7, 1);
    for (int c = 1; c <= 14; c++) begin
      tick();
      got = obs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL pausa_expira cycle %0d: got %b expected %b", c, got, exp);
      end
      if (c == 1) bus.SECADO = 1'b0;
      if (c == 10) bus.PUERTA_CERRADA = 1'b0;
      if (c == 12) bus.PUERTA_CERRADA = 1'b1;
    end
    bus.PUERTA_CERRADA = 1'b0;
    tick();
    bus.PUERTA_CERRADA = 1'b1;
    tick();
  endtask

  task automatic test_reset_medio();
    logic [9:0] got, exp;
    bus.LAVADO = 1'b1;
    repeat (17) tick();
    got = obs();
    n_checks++;
    if (got !== esperado(4)) begin
      n_fail++;
      $display("FAIL reset_medio_pre: got %b expected %b", got, esperado(4));
    end
    #3 reset = 1'b1;
    #1;
    got = obs();
    n_checks++;
    if (got !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_medio_async: got %b expected %b", got, 10'b0);
    end
    bus.LAVADO = 1'b0;
    bus.SECADO = 1'b1;
    tick();
    reset = 1'b0;
    encolar(5, 10); encolar(7, 1);
    for (int c = 1; c <= 11; c++) begin
      tick();
      got = obs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_medio_secado cycle %0d: got %b expected %b", c, got, exp);
      end
    end
    bus.SECADO = 1'b0;
    bus.PUERTA_CERRADA = 1'b0;
    tick();
    got = obs();
    n_checks++;
    if (got !== esperado(0)) begin
      n_fail++;
      $display("FAIL reset_medio_release: got %b expected %b", got, esperado(0));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_normal();
    test_pesado();
    test_sin_arranque();
    test_pausa();
    test_secado();
    test_pausa_expira();
    test_reset_medio();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
